// File: rtl/input_debouncer_pkg.sv
// Shared types and helpers for the input debouncer and its sub-blocks.
package input_debouncer_pkg;

    // Debouncer FSM states: settled levels and their qualification phases.
    typedef enum logic [1:0] {
        LOW   = 2'd0,
        CHK_H = 2'd1,
        HIGH  = 2'd2,
        CHK_L = 2'd3
    } state_t;

    // Counter width able to hold 0..stable_cycles.
    function automatic int cnt_width(input int stable_cycles);
        return $clog2(stable_cycles + 1);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Plain flop-chain synchroniser for a single asynchronous bit.
// No logic between stages so the chain can be treated as a metastability filter.
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stage_r;

    // Shift the raw input through the synchroniser stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_r <= '0;
        end else begin
            stage_r <= {stage_r[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stage_r[SYNC_STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Input debouncer: synchronises a raw input, requires STABLE_CYCLES
// consecutive samples at a new level before accepting it, and emits
// registered one-cycle rise/fall strobes alongside the clean level.
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    output logic a_clean,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int CNT_W = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam bit SINGLE = (STABLE_CYCLES == 1);

    logic             a_s;
    state_t           state_r;
    state_t           next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] next_cnt_s;
    logic             next_rise_s;
    logic             next_fall_s;
    logic             a_clean_r;
    logic             rise_r;
    logic             fall_r;
    logic             busy_r;

    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (a),
        .q  (a_s)
    );

    // Next-state, counter and strobe decisions from the synchronised sample.
    always_comb begin
        next_state_s = state_r;
        next_cnt_s   = cnt_r;
        next_rise_s  = 1'b0;
        next_fall_s  = 1'b0;
        case (state_r)
            LOW: begin
                if (a_s) begin
                    if (SINGLE) begin
                        next_state_s = HIGH;
                        next_rise_s  = 1'b1;
                    end else begin
                        next_state_s = CHK_H;
                        next_cnt_s   = CNT_ONE;
                    end
                end else begin
                    next_state_s = LOW;
                end
            end
            CHK_H: begin
                if (!a_s) begin
                    next_state_s = LOW;
                    next_cnt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_MAX) begin
                    next_state_s = HIGH;
                    next_cnt_s   = CNT_ZERO;
                    next_rise_s  = 1'b1;
                end else begin
                    next_cnt_s   = cnt_r + CNT_ONE;
                end
            end
            HIGH: begin
                if (!a_s) begin
                    if (SINGLE) begin
                        next_state_s = LOW;
                        next_fall_s  = 1'b1;
                    end else begin
                        next_state_s = CHK_L;
                        next_cnt_s   = CNT_ONE;
                    end
                end else begin
                    next_state_s = HIGH;
                end
            end
            CHK_L: begin
                if (a_s) begin
                    next_state_s = HIGH;
                    next_cnt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_MAX) begin
                    next_state_s = LOW;
                    next_cnt_s   = CNT_ZERO;
                    next_fall_s  = 1'b1;
                end else begin
                    next_cnt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                next_state_s = LOW;
                next_cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and registered outputs; outputs are decoded from the
    // next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= LOW;
            cnt_r     <= CNT_ZERO;
            a_clean_r <= 1'b0;
            rise_r    <= 1'b0;
            fall_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            cnt_r     <= next_cnt_s;
            a_clean_r <= (next_state_s == HIGH) || (next_state_s == CHK_L);
            rise_r    <= next_rise_s;
            fall_r    <= next_fall_s;
            busy_r    <= (next_state_s == CHK_H) || (next_state_s == CHK_L);
        end
    end

    assign a_clean = a_clean_r;
    assign rise    = rise_r;
    assign fall    = fall_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer: default instance plus a
// STABLE_CYCLES=1 instance, checked against hand-computed edge timings.
module tb_input_debouncer;

    logic clk;
    logic rst;
    logic a;
    logic a_clean, rise, fall, busy;
    logic a1;
    logic a1_clean, rise1, fall1, busy1;

    int errors = 0;
    int checks = 0;
    int rise_count;
    int fall_count;

    input_debouncer #(.SYNC_STAGES(2), .STABLE_CYCLES(4)) u_dut (
        .clk(clk), .rst(rst), .a(a),
        .a_clean(a_clean), .rise(rise), .fall(fall), .busy(busy)
    );

    input_debouncer #(.SYNC_STAGES(2), .STABLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .a(a1),
        .a_clean(a1_clean), .rise(rise1), .fall(fall1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_main(input string tag, input logic ec, input logic er,
                              input logic ef, input logic eb);
        check({tag, ".a_clean"}, {31'd0, a_clean}, {31'd0, ec});
        check({tag, ".rise"},    {31'd0, rise},    {31'd0, er});
        check({tag, ".fall"},    {31'd0, fall},    {31'd0, ef});
        check({tag, ".busy"},    {31'd0, busy},    {31'd0, eb});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bounce pattern applied before edges 1..9, then held high.
    logic [8:0] bounce;

    initial begin
        rst = 1'b1;
        a   = 1'b0;
        a1  = 1'b0;
        #1;
        check_main("reset_initial", 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (4) step();
        check_main("idle_low", 1'b0, 1'b0, 1'b0, 1'b0);

        // Glitch: three high samples then low; qualification aborts.
        a = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            if (i == 3) a = 1'b0;
            check_main($sformatf("glitch_e%0d", i), 1'b0, 1'b0, 1'b0, (i >= 3 && i <= 5));
        end

        // Clean rise: a set before edge 1, rise after edge 6.
        a = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            check_main($sformatf("rise_e%0d", i), (i >= 6), (i == 6), 1'b0, (i >= 3 && i <= 5));
        end

        // Clean fall from HIGH.
        a = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            step();
            check_main($sformatf("fall_e%0d", i), (i < 6), 1'b0, (i == 6), (i >= 3 && i <= 5));
        end

        // Bounce 1,0,1,1,0,1,1,1,1: single rise after edge 11.
        bounce = 9'b111101101;
        rise_count = 0;
        fall_count = 0;
        for (int i = 1; i <= 16; i++) begin
            if (i <= 9) a = bounce[i-1];
            else a = 1'b1;
            step();
            if (rise) rise_count++;
            if (fall) fall_count++;
            check($sformatf("bounce_rise_e%0d", i), {31'd0, rise}, {31'd0, (i == 11)});
        end
        check("bounce_rise_count", rise_count, 32'd1);
        check("bounce_fall_count", fall_count, 32'd0);
        check("bounce_clean", {31'd0, a_clean}, 32'd1);

        // Sweep: STABLE_CYCLES=1, two-cycle pulse -> rise after 3, fall after 5.
        a1 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 2) a1 = 1'b0;
            check($sformatf("s1_rise_e%0d", i),  {31'd0, rise1},    {31'd0, (i == 3)});
            check($sformatf("s1_fall_e%0d", i),  {31'd0, fall1},    {31'd0, (i == 5)});
            check($sformatf("s1_clean_e%0d", i), {31'd0, a1_clean}, {31'd0, (i == 3 || i == 4)});
            check($sformatf("s1_busy_e%0d", i),  {31'd0, busy1},    32'd0);
        end

        // Mid-cycle reset from HIGH with a=1: everything clears before next edge.
        #3;
        rst = 1'b1;
        #1;
        check_main("reset_async", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check_main("reset_held", 1'b0, 1'b0, 1'b0, 1'b0);

        // a high at reset release: normal rise 5 edges after first edge.
        #2;
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            check_main($sformatf("rel_e%0d", i), (i >= 6), (i == 6), 1'b0, (i >= 3 && i <= 5));
        end

        // Reset during the rise strobe cuts it; no strobe after release.
        rst = 1'b1;
        #1;
        check_main("reset_mid_strobe", 1'b0, 1'b0, 1'b0, 1'b0);
        a = 1'b0;
        step();
        #2;
        rst = 1'b0;
        rise_count = 0;
        fall_count = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (rise) rise_count++;
            if (fall) fall_count++;
        end
        check("post_reset_rise_count", rise_count, 32'd0);
        check("post_reset_fall_count", fall_count, 32'd0);
        check_main("post_reset_state", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Conditions a raw asynchronous single-bit input (button, external strobe) before it reaches the edge and pulse detector stages.
- Synchronises the input into the clk domain, then rejects glitches shorter than STABLE_CYCLES.
- Outputs a clean level plus registered one-cycle rise/fall strobes.
- Sits directly upstream of the posedge and one-cycle-pulse detectors; a_clean feeds their "a" input.

Parameters:
- SYNC_STAGES, default 2: synchroniser flop count; legal range >= 2.
- STABLE_CYCLES, default 4: consecutive synchronised samples at the new level required to accept a change; legal range >= 1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- a  input  1  raw input, asynchronous to clk
- a_clean  output  1  debounced level
- rise  output  1  one-cycle strobe; high in the first cycle a_clean is 1
- fall  output  1  one-cycle strobe; high in the first cycle a_clean is 0
- busy  output  1  high while a candidate change is being qualified (CHK_H or CHK_L)

Behaviour:
- Reset: one clock; rst is asynchronous and active-high. While rst is high:
  - all sync flops, counter, rise, fall and a_clean are 0
  - state is LOW, busy is 0
  - these values hold immediately, without waiting for a clk edge.
- Synchroniser: a shifts through SYNC_STAGES flops. a_s is the last stage. No logic is placed between stages.
- FSM has four states, all transitions on posedge clk. cnt is the qualification counter.
  - LOW (a_clean=0):
    - a_s=1 and STABLE_CYCLES=1: go to HIGH, pulse rise.
    - a_s=1 otherwise: go to CHK_H, cnt=1.
    - else stay.
  - CHK_H (a_clean=0, busy=1):
    - a_s=0: go to LOW, cnt=0; glitch rejected, no strobe.
    - a_s=1 and cnt==STABLE_CYCLES-1: go to HIGH, rise=1 next cycle, cnt=0.
    - a_s=1 otherwise: cnt+1.
  - HIGH and CHK_L: mirror images of LOW and CHK_H, with fall in place of rise.
- Latency: a stable from before clk edge k produces a change on a_clean/rise/fall after edge k+SYNC_STAGES+STABLE_CYCLES-1. With defaults this is 5 edges after k.
- Outputs are all registered; there is no combinational path from a to any output.
- Strobes:
  - rise and fall are exactly one cycle wide.
  - They are never high simultaneously.
  - Back-to-back strobes are separated by at least STABLE_CYCLES cycles.
- Counter: width $clog2(STABLE_CYCLES+1). It never exceeds STABLE_CYCLES-1 and never wraps.
- Boundary cases:
  - a toggling every cycle: the FSM bounces between LOW and CHK_H; a_clean never changes.
  - a high at reset release: handled as a normal rise. rise fires SYNC_STAGES+STABLE_CYCLES-1 edges after the first post-reset edge.
  - Reset asserted mid-qualification or mid-strobe: the strobe is cut immediately; no strobe follows deassertion unless requalified.

Decomposition:
- Package input_debouncer_pkg holds the state typedef (enum logic [1:0] {LOW, CHK_H, HIGH, CHK_L}).
- Sub-module sync_chain, parameterised by SYNC_STAGES, with ports clk, rst, d, q. It is reusable by other input blocks.
- The FSM, counter and strobe registers live in input_debouncer.

Test Plan:
All scenarios use defaults SYNC_STAGES=2, STABLE_CYCLES=4.
- Reset: assert rst with a=1 mid-cycle -> a_clean, rise, fall and busy all 0 before the next clk edge.
- Clean rise: a 0->1 before edge 10, then held -> rise=1 for exactly the cycle after edge 15, a_clean=1 from edge 15 on, busy high in the cycles after edges 12-14.
- Glitch: a=1 for 3 cycles, then 0 -> a_clean stays 0, rise never fires, busy returns to 0.
- Clean fall: from HIGH, a 1->0 held -> fall one cycle, 5 edges after the change; a_clean=0.
- Bounce: a alternates 1,0,1,1,0,1,1,1,1 -> exactly one rise, after the final 4-sample-stable run; no fall.
- Sweep: STABLE_CYCLES=1, a pulse held 2 cycles -> rise, then fall; each strobe 1 cycle wide, with latency SYNC_STAGES edges.
